// File: rtl/calc1_pkg.sv
// Shared command/response encodings and FSM state type for the calc1 port front-end.
package calc1_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_LSH = 4'd5;
  localparam logic [3:0] CMD_RSH = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    OP2,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/calc1_alu.sv
// Combinational calc1 arithmetic: unsigned add/sub with error on carry/borrow,
// logical shifts by the low five bits of op2; anything else reports an error.
module calc1_alu
  import calc1_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        cmd,
  input  logic [0:DATA_W-1] op1,
  input  logic [0:DATA_W-1] op2,
  output logic [0:DATA_W-1] result,
  output logic [1:0]        resp
);

  logic [DATA_W:0] sum_ext;
  logic [4:0]      shamt;

  assign sum_ext = {1'b0, op1} + {1'b0, op2};
  // Bit 0 is the MSB, so the numerically lowest five bits sit at the top indices.
  assign shamt   = op2[DATA_W-5:DATA_W-1];

  always_comb begin
    result = '0;
    resp   = RESP_ERR;
    case (cmd)
      CMD_ADD: begin
        if (!sum_ext[DATA_W]) begin
          result = sum_ext[DATA_W-1:0];
          resp   = RESP_OK;
        end
      end
      CMD_SUB: begin
        if (op1 >= op2) begin
          result = op1 - op2;
          resp   = RESP_OK;
        end
      end
      CMD_LSH: begin
        result = op1 << shamt;
        resp   = RESP_OK;
      end
      CMD_RSH: begin
        result = op1 >> shamt;
        resp   = RESP_OK;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc1_port_frontend.sv
// One calc1 port: two-cycle request capture, fixed-latency execute, one-cycle
// response, plus a saturating count of commands arriving while busy.
module calc1_port_frontend
  import calc1_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int EXEC_LAT = 3
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in,
  input  logic [0:DATA_W-1] req_data_in,
  output logic              in_rdy,
  output logic [1:0]        out_resp,
  output logic [0:DATA_W-1] out_data,
  output logic [7:0]        drop_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cmd;
  logic [0:DATA_W-1] op1;
  logic [0:DATA_W-1] op2;
  logic [3:0]        lat_cnt;
  logic [0:DATA_W-1] alu_result;
  logic [1:0]        alu_resp;
  logic              drop;

  calc1_alu #(.DATA_W(DATA_W)) u_alu (
    .cmd    (cmd),
    .op1    (op1),
    .op2    (op2),
    .result (alu_result),
    .resp   (alu_resp)
  );

  assign in_rdy = (state == IDLE);
  // The op2 cycle carries a don't-care command field, so only EXEC/RESP drop.
  assign drop   = ((state == EXEC) || (state == RESP)) && (req_cmd_in != CMD_NOP);

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_cmd_in != CMD_NOP) state_nxt = OP2;
      OP2:     state_nxt = EXEC;
      EXEC:    if (lat_cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cmd      <= CMD_NOP;
      op1      <= '0;
      op2      <= '0;
      lat_cnt  <= '0;
      out_resp <= RESP_NONE;
      out_data <= '0;
      drop_cnt <= '0;
    end else begin
      out_resp <= RESP_NONE;
      out_data <= '0;
      case (state)
        IDLE: begin
          if (req_cmd_in != CMD_NOP) begin
            cmd <= req_cmd_in;
            op1 <= req_data_in;
          end
        end
        OP2: begin
          op2     <= req_data_in;
          lat_cnt <= 4'(EXEC_LAT);
        end
        EXEC: begin
          if (lat_cnt == 4'd0) begin
            out_resp <= alu_resp;
            out_data <= alu_result;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: ;
      endcase
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_calc1_port_frontend.sv
// Scoreboard bench for calc1_port_frontend: directed and random requests against
// an arithmetic reference model, with response timing and drop counting checked.
module tb_calc1_port_frontend;

  localparam int DATA_W   = 32;
  localparam int EXEC_LAT = 3;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic        in_rdy;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_drop = 0;
  exp_t sb[$];

  calc1_port_frontend #(.DATA_W(DATA_W), .EXEC_LAT(EXEC_LAT)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .in_rdy      (in_rdy),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .drop_cnt    (drop_cnt)
  );

  always #5 c_clk = ~c_clk;

  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic in wide unsigned integers; codes 1/2/5/6 are ADD/SUB/LSH/RSH.
  function automatic void refModel(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                   output logic [1:0] resp, output logic [31:0] data);
    longint unsigned wa = 64'(a);
    longint unsigned wb = 64'(b);
    longint unsigned full;
    longint unsigned pow = 64'd1 << (b % 32);
    resp = 2'd2;
    data = 32'd0;
    case (cmd)
      4'd1: begin
        full = wa + wb;
        if (full < 64'h1_0000_0000) begin resp = 2'd1; data = full[31:0]; end
      end
      4'd2: begin
        if (wa >= wb) begin full = wa - wb; resp = 2'd1; data = full[31:0]; end
      end
      4'd5: begin full = wa * pow; resp = 2'd1; data = full[31:0]; end
      4'd6: begin full = wa / pow; resp = 2'd1; data = full[31:0]; end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issues one request at the current negedge (DUT must be idle) and runs the
  // busy window; busy_mode 0: NOPs, 1: one ADD right after op2, 2: random, 3: all ADD.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                               input int busy_mode);
    logic [1:0]  r;
    logic [31:0] d;
    logic [3:0]  bc;
    exp_t        e;
    checkOutput("in_rdy_idle", 64'(in_rdy), 64'd1);
    refModel(cmd, a, b, r, d);
    e.resp = r;
    e.data = d;
    e.due  = cyc + 3 + EXEC_LAT;
    sb.push_back(e);
    req_cmd_in  = cmd;
    req_data_in = a;
    @(negedge c_clk);
    checkOutput("in_rdy_busy", 64'(in_rdy), 64'd0);
    req_cmd_in  = 4'($urandom_range(0, 15));
    req_data_in = b;
    for (int i = 0; i < EXEC_LAT + 2; i++) begin
      @(negedge c_clk);
      case (busy_mode)
        0:       bc = 4'd0;
        1:       bc = (i == 0) ? 4'd1 : 4'd0;
        2:       bc = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
        default: bc = 4'd1;
      endcase
      req_cmd_in  = bc;
      req_data_in = $urandom;
      if (bc != 4'd0 && exp_drop < 255) exp_drop++;
    end
    @(negedge c_clk);
    req_cmd_in  = 4'd0;
    req_data_in = $urandom;
    checkOutput("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
  endtask

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge c_clk) begin
    exp_t e;
    if (out_resp != 2'd0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", 64'(out_resp), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("resp_code", 64'(out_resp), 64'(e.resp));
        checkOutput("resp_data", 64'(out_data), 64'(e.data));
        checkOutput("resp_cycle", 64'(cyc), 64'(e.due));
      end
    end else begin
      checkOutput("idle_data", 64'(out_data), 64'd0);
      if (sb.size() > 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        checkOutput("resp_timeout", 64'(out_resp), 64'(e.resp));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ops[4] = '{4'd1, 4'd2, 4'd5, 4'd6};

    reset       = 1'b0;
    req_cmd_in  = 4'd0;
    req_data_in = 32'd0;
    @(negedge c_clk);
    @(negedge c_clk);
    checkOutput("reset_in_rdy", 64'(in_rdy), 64'd1);
    checkOutput("reset_resp", 64'(out_resp), 64'd0);
    checkOutput("reset_drop", 64'(drop_cnt), 64'd0);
    reset = 1'b1;
    @(negedge c_clk);

    applyStimulus(4'd1, 32'hFFFF_0000, 32'h0000_FFFF, 0);
    applyStimulus(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    applyStimulus(4'd2, 32'h0000_FFFF, 32'h0000_FFFF, 0);
    applyStimulus(4'd2, 32'h0000_0000, 32'h0000_0001, 0);
    applyStimulus(4'd2, 32'h8000_0000, 32'h0000_0001, 0);
    applyStimulus(4'd5, 32'h0000_0001, 32'h0000_003F, 0);
    applyStimulus(4'd6, 32'h8000_0000, 32'h0000_0000, 0);
    applyStimulus(4'd4, 32'($urandom), 32'($urandom), 0);
    applyStimulus(4'd1, 32'h0000_0005, 32'h0000_0007, 1);
    checkOutput("single_drop", 64'(drop_cnt), 64'd1);

    for (int n = 0; n < 60; n++) begin
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : ops[$urandom_range(0, 3)];
      a = pickOperand();
      b = ($urandom_range(0, 5) == 0) ? a : pickOperand();
      applyStimulus(c, a, b, 2);
      for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge c_clk);
    end

    for (int n = 0; n < 60; n++) applyStimulus(4'd1, pickOperand(), pickOperand(), 3);
    checkOutput("drop_saturated", 64'(drop_cnt), 64'd255);

    // Abort an ADD in the middle of its execute phase.
    req_cmd_in  = 4'd1;
    req_data_in = 32'd1;
    @(negedge c_clk);
    req_data_in = 32'd2;
    @(negedge c_clk);
    req_cmd_in = 4'd0;
    @(negedge c_clk);
    #2 reset = 1'b0;
    #1;
    exp_drop = 0;
    checkOutput("async_reset_in_rdy", 64'(in_rdy), 64'd1);
    checkOutput("async_reset_resp", 64'(out_resp), 64'd0);
    checkOutput("async_reset_data", 64'(out_data), 64'd0);
    checkOutput("async_reset_drop", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < EXEC_LAT + 4; i++) @(negedge c_clk);
    reset = 1'b1;
    @(negedge c_clk);
    @(negedge c_clk);
    applyStimulus(4'd1, 32'h0000_0010, 32'h0000_0020, 0);

    @(negedge c_clk);
    @(negedge c_clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
